// File: rtl/sd_spi_link_phy_pkg.sv
// Shared constants for the SPI-mode SD front end: command indices, R1 bits,
// OCR, card states, response sizing and the CRC7 step function.
package sd_spi_pkg;

    localparam logic [5:0] CMD_GO_IDLE_STATE    = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND     = 6'd8;
    localparam logic [5:0] CMD_SEND_STATUS      = 6'd13;
    localparam logic [5:0] ACMD_SD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD          = 6'd55;
    localparam logic [5:0] CMD_READ_OCR         = 6'd58;

    localparam int unsigned R1_IDLE_BIT    = 0;
    localparam int unsigned R1_ILLEGAL_BIT = 2;
    localparam int unsigned R1_CRC_BIT     = 3;
    localparam logic [7:0]  R1_IDLE        = 8'h01 << R1_IDLE_BIT;
    localparam logic [7:0]  R1_ILLEGAL     = 8'h01 << R1_ILLEGAL_BIT;
    localparam logic [7:0]  R1_CRC_ERR     = 8'h01 << R1_CRC_BIT;

    localparam logic [31:0] OCR_VALUE = 32'hC0FF_8000;

    localparam logic [3:0] CARD_IDLE  = 4'd0;
    localparam logic [3:0] CARD_READY = 4'd1;
    localparam logic [3:0] CARD_TRAN  = 4'd4;

    localparam int unsigned RESP_W = 136;
    // One Ncr byte of 1s always precedes the response in the shifter.
    localparam int unsigned TX_W   = RESP_W + 8;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_spi_link_phy_if.sv
// Card-pin bundle for SPI mode: host drives SCLK/CS/MOSI, card drives MISO.
interface sd_spi_link_phy_if;
    logic sd_clk;
    logic sd_cs_n;
    logic sd_mosi;
    logic sd_miso;
    logic sd_miso_oe;

    modport master (output sd_clk, output sd_cs_n, output sd_mosi,
                    input  sd_miso, input sd_miso_oe);
    modport slave  (input  sd_clk, input sd_cs_n, input sd_mosi,
                    output sd_miso, output sd_miso_oe);
endinterface

// File: rtl/sd_spi_link_phy_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) over received command bits, MSB first.
module sd_crc7
    import sd_spi_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_r;

    // CRC register: clear has priority over a shift.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            crc_r <= 7'h00;
        end else if (clr) begin
            crc_r <= 7'h00;
        end else if (en) begin
            crc_r <= crc7_next(crc_r, din);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/sd_spi_link_phy.sv
// SPI-mode SD card front end: samples MOSI frames, decodes the init/status
// command set and shifts R1/R2/R3/R7 responses out on MISO.
module sd_spi_link_phy
    import sd_spi_pkg::*;
(
    input  logic              sys_clk,
    input  logic              sys_rst,
    sd_spi_link_phy_if.slave  pins,
    output logic              spi_mode,
    output logic [3:0]        card_state,
    output logic              cmd_valid,
    output logic [5:0]        cmd_last,
    output logic              err_cmd_crc,
    output logic              err_unhandled_cmd
);

    localparam logic [0:0] RX_HUNT    = 1'b0;
    localparam logic [0:0] RX_COLLECT = 1'b1;

    logic [2:0]        sclk_sync_r;
    logic [1:0]        cs_sync_r;
    logic [1:0]        mosi_sync_r;
    logic              sclk_rise_s, sclk_fall_s, cs_low_s, mosi_bit_s;
    logic              rx_en_s, start_s, frame_done_s, crc_clr_s, crc_en_s;
    logic [0:0]        rx_state_r;
    logic [46:0]       rx_shift_r;
    logic [5:0]        rx_cnt_r;
    logic [6:0]        crc_s;
    logic              frame_rdy_r, crc_ok_r;
    logic [5:0]        idx_r;
    logic [11:0]       arg_lo_r;
    logic              spi_mode_r, cmd_valid_r, app_armed_r, err_crc_r, err_unh_r;
    logic [3:0]        card_state_r;
    logic [5:0]        cmd_last_r;
    logic [1:0]        acmd_cnt_r;
    logic [7:0]        r1_base_s, resp_bits_s;
    logic [RESP_W-1:0] resp_s;
    logic [3:0]        nxt_state_s;
    logic [1:0]        nxt_acmd_s;
    logic              nxt_app_s, set_spi_s, set_crc_err_s, set_unh_s;
    logic              tx_busy_r, miso_r, oe_r;
    logic [TX_W-1:0]   tx_shift_r;
    logic [7:0]        tx_cnt_r;

    // Two-flop synchronisers; the third SCLK stage feeds edge detection.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 2'b11;
            mosi_sync_r <= 2'b11;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], pins.sd_clk};
            cs_sync_r   <= {cs_sync_r[0], pins.sd_cs_n};
            mosi_sync_r <= {mosi_sync_r[0], pins.sd_mosi};
        end
    end

    // Receiver strobes; the receiver is deaf while a response is shifting.
    always_comb begin
        sclk_rise_s  = sclk_sync_r[1] & ~sclk_sync_r[2];
        sclk_fall_s  = ~sclk_sync_r[1] & sclk_sync_r[2];
        cs_low_s     = ~cs_sync_r[1];
        mosi_bit_s   = mosi_sync_r[1];
        rx_en_s      = sclk_rise_s & cs_low_s & ~tx_busy_r;
        start_s      = (rx_state_r == RX_HUNT) & ~rx_shift_r[0] & mosi_bit_s;
        frame_done_s = rx_en_s & (rx_state_r == RX_COLLECT) & (rx_cnt_r == 6'd47);
        // A run of leading zeros leaves the CRC at zero, so clearing on every
        // non-start hunt bit and shifting the start '1' seeds it correctly.
        crc_clr_s    = rx_en_s & (((rx_state_r == RX_HUNT) & ~start_s) | frame_done_s);
        crc_en_s     = rx_en_s & (((rx_state_r == RX_HUNT) & start_s) |
                                  ((rx_state_r == RX_COLLECT) & (rx_cnt_r <= 6'd39)));
    end

    // Frame collector: hunt for a 0,1 pair then take 46 more bits.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_state_r <= RX_HUNT;
            rx_shift_r <= {47{1'b1}};
            rx_cnt_r   <= 6'd0;
        end else if (!cs_low_s) begin
            rx_state_r <= RX_HUNT;
            rx_shift_r <= {47{1'b1}};
            rx_cnt_r   <= 6'd0;
        end else if (rx_en_s) begin
            rx_shift_r <= {rx_shift_r[45:0], mosi_bit_s};
            case (rx_state_r)
                RX_HUNT: begin
                    rx_state_r <= start_s ? RX_COLLECT : RX_HUNT;
                    rx_cnt_r   <= start_s ? 6'd2 : 6'd0;
                end
                RX_COLLECT: begin
                    rx_state_r <= (rx_cnt_r == 6'd47) ? RX_HUNT : RX_COLLECT;
                    rx_cnt_r   <= (rx_cnt_r == 6'd47) ? 6'd0 : rx_cnt_r + 6'd1;
                end
                default: begin
                    rx_state_r <= RX_HUNT;
                    rx_cnt_r   <= 6'd0;
                end
            endcase
        end else begin
            rx_state_r <= rx_state_r;
            rx_shift_r <= rx_shift_r;
            rx_cnt_r   <= rx_cnt_r;
        end
    end

    sd_crc7 u_crc7 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (crc_clr_s),
        .en      (crc_en_s),
        .din     (mosi_bit_s),
        .crc     (crc_s)
    );

    // Latch the fields of a complete frame; a frame with end bit 0 is dropped.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_rdy_r <= 1'b0;
            idx_r       <= 6'd0;
            arg_lo_r    <= 12'd0;
            crc_ok_r    <= 1'b0;
        end else if (frame_done_s) begin
            frame_rdy_r <= mosi_bit_s & (rx_shift_r[46:45] == 2'b01);
            idx_r       <= rx_shift_r[44:39];
            arg_lo_r    <= rx_shift_r[18:7];
            crc_ok_r    <= (crc_s == rx_shift_r[6:0]);
        end else begin
            frame_rdy_r <= 1'b0;
            idx_r       <= idx_r;
            arg_lo_r    <= arg_lo_r;
            crc_ok_r    <= crc_ok_r;
        end
    end

    // Command decode: response image (left-aligned), its length and next state.
    always_comb begin
        r1_base_s     = {7'b0000000, card_state_r == CARD_IDLE};
        resp_s        = {RESP_W{1'b0}};
        resp_bits_s   = 8'd8;
        nxt_state_s   = card_state_r;
        nxt_app_s     = 1'b0;
        nxt_acmd_s    = acmd_cnt_r;
        set_spi_s     = 1'b0;
        set_crc_err_s = 1'b0;
        set_unh_s     = 1'b0;
        if (((idx_r == CMD_GO_IDLE_STATE) || (idx_r == CMD_SEND_IF_COND)) && !crc_ok_r) begin
            resp_s[RESP_W-1 -: 8] = r1_base_s | R1_CRC_ERR;
            nxt_app_s             = app_armed_r;
            set_crc_err_s         = 1'b1;
        end else begin
            case (idx_r)
                CMD_GO_IDLE_STATE: begin
                    resp_s[RESP_W-1 -: 8] = R1_IDLE;
                    set_spi_s             = 1'b1;
                    nxt_state_s           = CARD_IDLE;
                    nxt_acmd_s            = 2'd0;
                end
                CMD_SEND_IF_COND: begin
                    resp_s[RESP_W-1 -: 40] = {r1_base_s, 8'h00, 8'h00, 4'h0, arg_lo_r};
                    resp_bits_s            = 8'd40;
                end
                CMD_APP_CMD: begin
                    resp_s[RESP_W-1 -: 8] = r1_base_s;
                    nxt_app_s             = 1'b1;
                end
                CMD_READ_OCR: begin
                    resp_s[RESP_W-1 -: 40] = {r1_base_s, OCR_VALUE};
                    resp_bits_s            = 8'd40;
                end
                CMD_SEND_STATUS: begin
                    resp_s[RESP_W-1 -: 16] = {r1_base_s, 8'h00};
                    resp_bits_s            = 8'd16;
                end
                ACMD_SD_SEND_OP_COND: begin
                    if (app_armed_r && (acmd_cnt_r == 2'd0)) begin
                        resp_s[RESP_W-1 -: 8] = R1_IDLE;
                        nxt_acmd_s            = 2'd1;
                    end else if (app_armed_r) begin
                        resp_s[RESP_W-1 -: 8] = 8'h00;
                        nxt_acmd_s            = 2'd2;
                        nxt_state_s           = CARD_TRAN;
                    end else begin
                        resp_s[RESP_W-1 -: 8] = r1_base_s | R1_ILLEGAL;
                        set_unh_s             = 1'b1;
                    end
                end
                default: begin
                    resp_s[RESP_W-1 -: 8] = r1_base_s | R1_ILLEGAL;
                    set_unh_s             = 1'b1;
                end
            endcase
        end
    end

    // Link-layer state, updated once per accepted frame.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cmd_valid_r  <= 1'b0;
            cmd_last_r   <= 6'd0;
            spi_mode_r   <= 1'b0;
            card_state_r <= CARD_IDLE;
            app_armed_r  <= 1'b0;
            acmd_cnt_r   <= 2'd0;
            err_crc_r    <= 1'b0;
            err_unh_r    <= 1'b0;
        end else if (frame_rdy_r) begin
            cmd_valid_r  <= 1'b1;
            cmd_last_r   <= idx_r;
            spi_mode_r   <= spi_mode_r | set_spi_s;
            card_state_r <= nxt_state_s;
            app_armed_r  <= nxt_app_s;
            acmd_cnt_r   <= nxt_acmd_s;
            err_crc_r    <= err_crc_r | set_crc_err_s;
            err_unh_r    <= err_unh_r | set_unh_s;
        end else begin
            cmd_valid_r  <= 1'b0;
            cmd_last_r   <= cmd_last_r;
            spi_mode_r   <= spi_mode_r;
            card_state_r <= card_state_r;
            app_armed_r  <= app_armed_r;
            acmd_cnt_r   <= acmd_cnt_r;
            err_crc_r    <= err_crc_r;
            err_unh_r    <= err_unh_r;
        end
    end

    // MISO shifter: Ncr byte then response, one bit per SCLK fall; CS high aborts.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_busy_r  <= 1'b0;
            tx_shift_r <= {TX_W{1'b1}};
            tx_cnt_r   <= 8'd0;
            miso_r     <= 1'b1;
            oe_r       <= 1'b0;
        end else begin
            oe_r <= cs_low_s;
            if (!cs_low_s) begin
                tx_busy_r  <= 1'b0;
                tx_shift_r <= tx_shift_r;
                tx_cnt_r   <= 8'd0;
                miso_r     <= 1'b1;
            end else if (frame_rdy_r) begin
                tx_busy_r  <= 1'b1;
                tx_shift_r <= {8'hFF, resp_s};
                tx_cnt_r   <= resp_bits_s + 8'd8;
                miso_r     <= miso_r;
            end else if (tx_busy_r && sclk_fall_s && (tx_cnt_r != 8'd0)) begin
                tx_busy_r  <= 1'b1;
                tx_shift_r <= {tx_shift_r[TX_W-2:0], 1'b1};
                tx_cnt_r   <= tx_cnt_r - 8'd1;
                miso_r     <= tx_shift_r[TX_W-1];
            end else if (tx_busy_r && sclk_fall_s) begin
                tx_busy_r  <= 1'b0;
                tx_shift_r <= tx_shift_r;
                tx_cnt_r   <= 8'd0;
                miso_r     <= 1'b1;
            end else begin
                tx_busy_r  <= tx_busy_r;
                tx_shift_r <= tx_shift_r;
                tx_cnt_r   <= tx_cnt_r;
                miso_r     <= miso_r;
            end
        end
    end

    assign pins.sd_miso      = miso_r;
    assign pins.sd_miso_oe   = oe_r;
    assign spi_mode          = spi_mode_r;
    assign card_state        = card_state_r;
    assign cmd_valid         = cmd_valid_r;
    assign cmd_last          = cmd_last_r;
    assign err_cmd_crc       = err_crc_r;
    assign err_unhandled_cmd = err_unh_r;

endmodule

// File: tb/tb_sd_spi_link_phy.sv
// Directed bench for sd_spi_link_phy: a bit-banged SPI host sends command
// frames and compares every response byte against hand-computed values.
module tb_sd_spi_link_phy;

    localparam int HALF = 8;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       spi_mode, cmd_valid, err_cmd_crc, err_unhandled_cmd;
    logic [3:0] card_state;
    logic [5:0] cmd_last;
    logic [7:0] d;
    int         tests = 0;
    int         fails = 0;
    int         valid_cnt = 0;

    sd_spi_link_phy_if pins ();

    sd_spi_link_phy dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .pins              (pins),
        .spi_mode          (spi_mode),
        .card_state        (card_state),
        .cmd_valid         (cmd_valid),
        .cmd_last          (cmd_last),
        .err_cmd_crc       (err_cmd_crc),
        .err_unhandled_cmd (err_unhandled_cmd)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (cmd_valid === 1'b1) valid_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            pins.sd_mosi = tx[i];
            repeat (HALF) @(negedge sys_clk);
            rx[i] = pins.sd_miso;
            pins.sd_clk = 1'b1;
            repeat (HALF) @(negedge sys_clk);
            pins.sd_clk = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [47:0] f);
        logic [7:0] r;
        for (int b = 5; b >= 0; b--) xfer(f[b*8 +: 8], r);
    endtask

    task automatic expect_resp(input string tag, input int n, input logic [63:0] exp);
        logic [7:0]  r;
        logic [63:0] acc;
        xfer(8'hFF, r);
        check({tag, "_ncr"}, {56'd0, r}, 64'hFF);
        acc = 64'd0;
        for (int k = 0; k < n; k++) begin
            xfer(8'hFF, r);
            acc = {acc[55:0], r};
        end
        check(tag, acc, exp);
        xfer(8'hFF, r);
        check({tag, "_after"}, {56'd0, r}, 64'hFF);
    endtask

    initial begin
        sys_rst      = 1'b1;
        pins.sd_clk  = 1'b0;
        pins.sd_cs_n = 1'b1;
        pins.sd_mosi = 1'b1;
        repeat (4) @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_miso", {63'd0, pins.sd_miso}, 64'd1);
        check("rst_oe", {63'd0, pins.sd_miso_oe}, 64'd0);
        check("rst_spi_mode", {63'd0, spi_mode}, 64'd0);
        check("rst_card_state", {60'd0, card_state}, 64'd0);
        check("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
        check("rst_cmd_last", {58'd0, cmd_last}, 64'd0);
        check("rst_err_crc", {63'd0, err_cmd_crc}, 64'd0);
        check("rst_err_unh", {63'd0, err_unhandled_cmd}, 64'd0);

        pins.sd_cs_n = 1'b0;
        repeat (6) @(negedge sys_clk);
        check("oe_cs_low", {63'd0, pins.sd_miso_oe}, 64'd1);

        xfer(8'h00, d);
        send_cmd(48'h40_0000_0000_95);
        expect_resp("cmd0", 1, 64'h01);
        check("spi_mode", {63'd0, spi_mode}, 64'd1);

        xfer(8'hFF, d);
        send_cmd(48'h40_0000_0000_95);
        expect_resp("cmd0_ff_lead", 1, 64'h01);
        check("cmd_last_0", {58'd0, cmd_last}, 64'd0);

        send_cmd(48'h48_0000_01AA_87);
        expect_resp("cmd8", 5, 64'h01_0000_01AA);
        check("cmd_last_8", {58'd0, cmd_last}, 64'd8);

        send_cmd(48'h48_0000_01AA_89);
        expect_resp("cmd8_badcrc", 1, 64'h09);
        check("err_cmd_crc", {63'd0, err_cmd_crc}, 64'd1);
        check("err_unh_clear", {63'd0, err_unhandled_cmd}, 64'd0);

        send_cmd(48'h77_0000_0000_65);
        expect_resp("cmd55_a", 1, 64'h01);
        send_cmd(48'h69_4000_0000_77);
        expect_resp("acmd41_a", 1, 64'h01);
        check("state_idle", {60'd0, card_state}, 64'd0);
        send_cmd(48'h77_0000_0000_65);
        expect_resp("cmd55_b", 1, 64'h01);
        send_cmd(48'h69_4000_0000_77);
        expect_resp("acmd41_b", 1, 64'h00);
        check("state_tran", {60'd0, card_state}, 64'd4);

        send_cmd(48'h7A_0000_0000_FD);
        expect_resp("cmd58", 5, 64'h00_C0FF_8000);
        send_cmd(48'h4D_0000_0000_0D);
        expect_resp("cmd13", 2, 64'h0000);
        check("cmd_last_13", {58'd0, cmd_last}, 64'd13);

        // End bit 0: frame must be dropped silently.
        send_cmd(48'h7A_0000_0000_FC);
        xfer(8'hFF, d);
        check("endbit0_b0", {56'd0, d}, 64'hFF);
        xfer(8'hFF, d);
        check("endbit0_b1", {56'd0, d}, 64'hFF);
        check("endbit0_valid", 64'(valid_cnt), 64'd10);
        pins.sd_cs_n = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        pins.sd_cs_n = 1'b0;
        repeat (HALF) @(negedge sys_clk);

        send_cmd(48'h7A_0000_0000_FD);
        xfer(8'hFF, d);
        check("abort_ncr", {56'd0, d}, 64'hFF);
        xfer(8'hFF, d);
        check("abort_b0", {56'd0, d}, 64'h00);
        xfer(8'hFF, d);
        check("abort_b1", {56'd0, d}, 64'hC0);
        pins.sd_cs_n = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        check("abort_miso", {63'd0, pins.sd_miso}, 64'd1);
        check("abort_oe", {63'd0, pins.sd_miso_oe}, 64'd0);
        pins.sd_cs_n = 1'b0;
        repeat (HALF) @(negedge sys_clk);
        xfer(8'hFF, d);

        send_cmd(48'h45_0000_0000_FF);
        expect_resp("cmd5", 1, 64'h04);
        check("err_unh", {63'd0, err_unhandled_cmd}, 64'd1);
        check("state_kept", {60'd0, card_state}, 64'd4);
        check("valid_count", 64'(valid_cnt), 64'd12);

        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("mid_rst_spi_mode", {63'd0, spi_mode}, 64'd0);
        check("mid_rst_state", {60'd0, card_state}, 64'd0);
        check("mid_rst_cmd_last", {58'd0, cmd_last}, 64'd0);
        check("mid_rst_err_crc", {63'd0, err_cmd_crc}, 64'd0);
        check("mid_rst_err_unh", {63'd0, err_unhandled_cmd}, 64'd0);
        check("mid_rst_miso", {63'd0, pins.sd_miso}, 64'd1);
        check("mid_rst_oe", {63'd0, pins.sd_miso_oe}, 64'd0);
        sys_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
